// File: rtl/control.sv
// Two-button up/down counter with a 3-bit LED display.
// Each button is synchronized, debounced, and edge-detected on the press (falling) edge.
module control #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter bit LED_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button_0,
    input  logic       button_1,
    output logic [2:0] led
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0] LED_RESET = LED_ACTIVE_LOW ? 3'b111 : 3'b000;

    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    logic [1:0]    deb;
    logic [1:0]    ev;
    logic [CW-1:0] cnt [2];
    logic [2:0]    count;

    // Index 0 is button_0 (down), index 1 is button_1 (up).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_a <= 2'b11;
            sync_b <= 2'b11;
        end else begin
            sync_a <= {button_1, button_0};
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb <= 2'b11;
            ev  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                ev[i] <= 1'b0;
                if (sync_b[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    // Accept the new level; a press is a debounced fall to 0.
                    deb[i] <= sync_b[i];
                    cnt[i] <= '0;
                    ev[i]  <= ~sync_b[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 3'd0;
            led   <= LED_RESET;
        end else begin
            case (ev)
                2'b01:   count <= count - 3'd1;
                2'b10:   count <= count + 3'd1;
                default: count <= count;
            endcase
            led <= LED_ACTIVE_LOW ? ~count : count;
        end
    end

endmodule

// File: tb/tb_control.sv
// Randomized and directed bench for control, compared every cycle against
// a window-based behavioural model of the debounced counter.
module tb_control;

    localparam int DB = 3;

    logic       clk;
    logic       rst_n;
    logic       button_0;
    logic       button_1;
    logic [2:0] led;

    int checks;
    int errors;
    int cyc;

    control #(.DEBOUNCE_CYCLES(DB), .LED_ACTIVE_LOW(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .button_0 (button_0),
        .button_1 (button_1),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a button's level is seen by the debouncer two edges after sampling;
    // the accepted level flips once the last DB seen samples all disagree with it.
    logic          m_valid;
    logic [1:0]    m_dl   [2];
    logic [DB-1:0] m_hist [2];
    logic [1:0]    m_deb;
    logic [1:0]    m_ev;
    logic [2:0]    m_count;
    logic [2:0]    m_led;

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        logic [1:0] inb;
        logic       seen;
        logic [DB-1:0] other;
        inb = {button_1, button_0};
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                m_dl[b]   = 2'b11;
                m_hist[b] = '1;
            end
            m_deb   = 2'b11;
            m_ev    = 2'b00;
            m_count = 3'd0;
            m_led   = 3'b111;
            m_valid = 1'b1;
        end else begin
            m_led = ~m_count;
            m_count = 3'((int'(m_count) + int'(m_ev[1]) - int'(m_ev[0]) + 8) % 8);
            for (int b = 0; b < 2; b++) begin
                seen      = m_dl[b][1];
                m_dl[b]   = {m_dl[b][0], inb[b]};
                m_hist[b] = (m_hist[b] << 1) | DB'(seen);
                other     = m_deb[b] ? '0 : '1;
                m_ev[b]   = 1'b0;
                if (m_hist[b] == other) begin
                    m_deb[b] = seen;
                    m_ev[b]  = ~seen;
                end
            end
        end
    end

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %b want %b", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (m_valid) check3("led_vs_model", led, m_led);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int which, input int len);
        if (which == 0) button_0 = 1'b0;
        else            button_1 = 1'b0;
        idle(len);
        button_0 = 1'b1;
        button_1 = 1'b1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        button_0 = 1'b1;
        button_1 = 1'b1;
        idle(3);
        rst_n = 1'b1;
        check3("reset_led", led, 3'b111);
        idle(100);
        check3("idle_led", led, 3'b111);
        check3("idle_count", m_count, 3'd0);

        // Up press: visible within 8 rising edges of the fall.
        @(negedge clk);
        button_1 = 1'b0;
        repeat (5) @(negedge clk);
        button_1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 check3("latency_led", led, 3'b110);
        idle(20);
        check3("inc_held", led, 3'b110);
        check3("inc_count", m_count, 3'd1);

        press(0, 5);
        idle(20);
        check3("dec_led", led, 3'b111);

        press(1, 1);
        idle(10);
        press(1, 2);
        idle(20);
        check3("glitch_led", led, 3'b111);

        press(0, 5);
        idle(20);
        check3("wrap_down", led, 3'b000);
        for (int i = 0; i < 8; i++) begin
            press(1, 5);
            idle(12);
        end
        check3("eight_up", led, 3'b000);

        button_0 = 1'b0;
        button_1 = 1'b0;
        idle(5);
        button_0 = 1'b1;
        button_1 = 1'b1;
        idle(20);
        check3("both_led", led, 3'b000);

        // Long hold: one increment only (7 -> 0).
        button_1 = 1'b0;
        idle(50);
        check3("hold_one", led, 3'b111);
        check3("hold_count", m_count, 3'd0);

        // Reset pulse mid-hold, button still held across it.
        rst_n = 1'b0;
        idle(1);
        check3("mid_reset", led, 3'b111);
        rst_n = 1'b1;
        idle(50);
        button_1 = 1'b1;
        idle(20);
        check3("after_reset", led, 3'b110);

        // Reset during a pending debounce discards it.
        button_0 = 1'b0;
        idle(3);
        rst_n = 1'b0;
        button_0 = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(20);
        check3("pend_discard", led, 3'b111);

        for (int i = 0; i < 300; i++) begin
            int act;
            act = int'($urandom_range(0, 19));
            if (act == 0) begin
                rst_n = 1'b0;
                idle(int'($urandom_range(1, 2)));
                rst_n = 1'b1;
            end else begin
                button_0 = (act % 3 == 1) ? 1'b1 : 1'b0;
                button_1 = (act % 3 == 2) ? 1'b1 : 1'b0;
                idle(int'($urandom_range(1, 8)));
                button_0 = 1'b1;
                button_1 = 1'b1;
                idle(int'($urandom_range(0, 10)));
            end
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 3, meaning consecutive stable synchronized samples required to accept a button level change; legal range 1..255.
REQ-002 Parameter LED_ACTIVE_LOW, default 1, meaning led drives the inverted count when 1 and the true count when 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 button_0  input  1  asynchronous push-button, active-low (1 = released); a press decrements the count.
REQ-006 button_1  input  1  asynchronous push-button, active-low (1 = released); a press increments the count.
REQ-007 led  output  3  registered count display, polarity per LED_ACTIVE_LOW.

Function
REQ-008 Each button SHALL pass through its own 2-flop synchronizer before any other logic.
REQ-009 Each button SHALL have a debounced level register and a stability counter wide enough for DEBOUNCE_CYCLES.
REQ-010 Stability counter SHALL reset to 0 whenever synchronized level equals debounced level, and SHALL increment otherwise.
REQ-011 Debounced level SHALL take the synchronized level, and the stability counter SHALL clear, on the edge at which the counter would reach DEBOUNCE_CYCLES.
REQ-012 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change the debounced level.
REQ-013 A press event SHALL be a one-cycle pulse, generated only on a debounced 1->0 transition.
REQ-014 Release transitions (0->1) SHALL NOT generate events.
REQ-015 Count SHALL be a 3-bit register, updated the cycle after a press event.
REQ-016 Count SHALL go +1 on a button_1 event alone, with wrap 7->0.
REQ-017 Count SHALL go -1 on a button_0 event alone, with wrap 0->7.
REQ-018 Count SHALL remain unchanged when button_0 and button_1 events occur in the same cycle.
REQ-019 A button held low indefinitely SHALL produce exactly one event, with no auto-repeat.
REQ-020 led SHALL be registered, equal to ~count when LED_ACTIVE_LOW=1, else count, and updated the cycle after count.
REQ-021 With DEBOUNCE_CYCLES=3, led SHALL reflect a press no later than 8 clk edges after the button input falls.
REQ-022 The design SHALL contain no latches, no combinational path from any input to led, and no state other than synchronizers, debouncers, edge detectors, count and led registers.

Reset
REQ-023 While rst_n=0 at a rising edge, all synchronizer flops and debounced levels SHALL load 1, stability counters and event pulses 0, count 0, and led 3'b111 (LED_ACTIVE_LOW=1) or 3'b000 (LED_ACTIVE_LOW=0).
REQ-024 A button held low through reset deassertion SHALL register as a press once it has been stable for DEBOUNCE_CYCLES after synchronization.
REQ-025 Reset asserted mid-debounce or mid-press SHALL discard the pending change, with no event after reset.

Verification
REQ-026 Reset, buttons high for 100 cycles -> led stays 3'b111, count 0.
REQ-027 button_1 low for 5 cycles then high -> led 3'b110 within 8 cycles and held; exactly one increment.
REQ-028 Then button_0 low for 5 cycles -> led returns to 3'b111.
REQ-029 button_1 low for 1 cycle and for 2 cycles (glitches) -> led unchanged.
REQ-030 From count 0, button_0 press -> count 7 (led 3'b000); then 8 button_1 presses -> count 7 again; simultaneous presses of both buttons -> unchanged.
REQ-031 Hold button_1 low for 50 cycles -> exactly one increment; assert rst_n=0 for 1 cycle mid-hold -> led 3'b111 on the next edge, then one increment after release of reset.
